airi5c_wb_writeback: RTL and testbench

Writeback stage that consumes the WB pipeline-register outputs and produces the single register-file write port plus the instret pulse.
- Selects the result source: ALU, load data, CSR read data, or PCPI coprocessor.
- Aligns and sign/zero-extends load data and waits for the data-memory response.
- Sequences 64-bit PCPI results as two consecutive writes, to rd and then rd+1.
- Back-pressures the WB pipeline registers via stall_WB_o.

---
 rtl/airi5c_wb_writeback.sv | 204 ++++++++++++++++++++
 tb/tb_airi5c_wb_writeback.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_wb_writeback.sv
// Writeback stage: picks the result source, aligns load data, sequences 64-bit
// PCPI results as two writes and drives the registered register-file write port.
module airi5c_wb_writeback #(
  parameter int XPR_LEN        = 32,
  parameter int MEM_TYPE_WIDTH = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      prev_killed_WB_i,
  input  logic                      had_ex_WB_i,
  input  logic                      wb_en_i,
  input  logic [1:0]                wb_src_sel_i,
  input  logic [XPR_LEN-1:0]        inst_wb_i,
  input  logic [XPR_LEN-1:0]        alu_out_wb_i,
  input  logic [XPR_LEN-1:0]        csr_rdata_wb_i,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_type_wb_i,
  input  logic [XPR_LEN-1:0]        dmem_rdata_i,
  input  logic                      dmem_rvalid_i,
  input  logic [XPR_LEN-1:0]        pcpi_rd_wb_i,
  input  logic [XPR_LEN-1:0]        pcpi_rd2_wb_i,
  input  logic                      pcpi_use_rd64_wb_i,
  output logic                      stall_WB_o,
  output logic                      rf_we_o,
  output logic [4:0]                rf_waddr_o,
  output logic [XPR_LEN-1:0]        rf_wdata_o,
  output logic                      retire_o
);

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_CSR  = 2'd2;
  localparam logic [1:0] SRC_PCPI = 2'd3;

  localparam logic [MEM_TYPE_WIDTH-1:0] MT_LB  = MEM_TYPE_WIDTH'(0);
  localparam logic [MEM_TYPE_WIDTH-1:0] MT_LH  = MEM_TYPE_WIDTH'(1);
  localparam logic [MEM_TYPE_WIDTH-1:0] MT_LW  = MEM_TYPE_WIDTH'(2);
  localparam logic [MEM_TYPE_WIDTH-1:0] MT_LBU = MEM_TYPE_WIDTH'(4);
  localparam logic [MEM_TYPE_WIDTH-1:0] MT_LHU = MEM_TYPE_WIDTH'(5);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE_HI = 2'd2
  } state_t;

  // Extract and extend the addressed byte/half; unknown types pass the raw word.
  function automatic logic [XPR_LEN-1:0] load_align(
    input logic [MEM_TYPE_WIDTH-1:0] mtype,
    input logic [1:0]                off,
    input logic [XPR_LEN-1:0]        rdata
  );
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [XPR_LEN-1:0] res_v;
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (mtype)
      MT_LB:   res_v = {{(XPR_LEN-8){byte_v[7]}}, byte_v};
      MT_LBU:  res_v = {{(XPR_LEN-8){1'b0}}, byte_v};
      MT_LH:   res_v = {{(XPR_LEN-16){half_v[15]}}, half_v};
      MT_LHU:  res_v = {{(XPR_LEN-16){1'b0}}, half_v};
      MT_LW:   res_v = rdata;
      default: res_v = rdata;
    endcase
    return res_v;
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic               valid_s;
  logic [4:0]         rd_s;
  logic [XPR_LEN-1:0] load_data_s;
  logic               stall_s;
  logic               we_s;
  logic [4:0]         waddr_s;
  logic [XPR_LEN-1:0] wdata_s;
  logic               retire_s;
  logic               hi_load_s;
  logic [4:0]         hi_addr_r;
  logic [XPR_LEN-1:0] hi_data_r;
  logic               rf_we_r;
  logic [4:0]         rf_waddr_r;
  logic [XPR_LEN-1:0] rf_wdata_r;
  logic               retire_r;
  logic               unused_inst_bits_s;

  assign valid_s            = ~prev_killed_WB_i & ~had_ex_WB_i;
  assign rd_s               = inst_wb_i[11:7];
  assign load_data_s        = load_align(dmem_type_wb_i, alu_out_wb_i[1:0], dmem_rdata_i);
  assign unused_inst_bits_s = ^{inst_wb_i[XPR_LEN-1:12], inst_wb_i[6:0]};

  // Writeback decision: next state, stall and the write to capture this cycle.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    we_s         = 1'b0;
    waddr_s      = 5'd0;
    wdata_s      = {XPR_LEN{1'b0}};
    retire_s     = 1'b0;
    hi_load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!valid_s) begin
          retire_s = 1'b0;
        end else if (!wb_en_i) begin
          retire_s = 1'b1;
        end else begin
          waddr_s = rd_s;
          case (wb_src_sel_i)
            SRC_ALU: begin
              we_s     = 1'b1;
              wdata_s  = alu_out_wb_i;
              retire_s = 1'b1;
            end
            SRC_CSR: begin
              we_s     = 1'b1;
              wdata_s  = csr_rdata_wb_i;
              retire_s = 1'b1;
            end
            SRC_MEM: begin
              if (dmem_rvalid_i) begin
                we_s     = 1'b1;
                wdata_s  = load_data_s;
                retire_s = 1'b1;
              end else begin
                stall_s      = 1'b1;
                next_state_s = ST_WAIT_MEM;
              end
            end
            SRC_PCPI: begin
              we_s    = 1'b1;
              wdata_s = pcpi_rd_wb_i;
              // Low half goes out now; the retire travels with the high half.
              if (pcpi_use_rd64_wb_i) begin
                stall_s      = 1'b1;
                hi_load_s    = 1'b1;
                next_state_s = ST_WRITE_HI;
              end else begin
                retire_s = 1'b1;
              end
            end
            default: begin
              we_s = 1'b0;
            end
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (dmem_rvalid_i) begin
          we_s         = 1'b1;
          waddr_s      = rd_s;
          wdata_s      = load_data_s;
          retire_s     = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_WRITE_HI: begin
        we_s         = 1'b1;
        waddr_s      = hi_addr_r;
        wdata_s      = hi_data_r;
        retire_s     = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, captured high-half and registered register-file port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      hi_addr_r  <= 5'd0;
      hi_data_r  <= {XPR_LEN{1'b0}};
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= {XPR_LEN{1'b0}};
      retire_r   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      rf_we_r    <= we_s & (waddr_s != 5'd0);
      rf_waddr_r <= waddr_s;
      rf_wdata_r <= wdata_s;
      retire_r   <= retire_s;
      if (hi_load_s) begin
        hi_addr_r <= rd_s + 5'd1;
        hi_data_r <= pcpi_rd2_wb_i;
      end else begin
        hi_addr_r <= hi_addr_r;
        hi_data_r <= hi_data_r;
      end
    end
  end

  assign stall_WB_o = stall_s & ~rst_i;
  assign rf_we_o    = rf_we_r;
  assign rf_waddr_o = rf_waddr_r;
  assign rf_wdata_o = rf_wdata_r;
  assign retire_o   = retire_r;

endmodule

// File: tb/tb_airi5c_wb_writeback.sv
// Scoreboard bench for airi5c_wb_writeback: directed ops push expected
// register-file/retire events, a negedge monitor pops and compares them.
module tb_airi5c_wb_writeback;

  logic        clk;
  logic        rst;
  logic        prev_killed;
  logic        had_ex;
  logic        wb_en;
  logic [1:0]  src_sel;
  logic [31:0] inst;
  logic [31:0] alu_out;
  logic [31:0] csr_rdata;
  logic [2:0]  dmem_type;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [31:0] pcpi_rd;
  logic [31:0] pcpi_rd2;
  logic        pcpi_rd64;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ret;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  airi5c_wb_writeback #(.XPR_LEN(32), .MEM_TYPE_WIDTH(3)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .prev_killed_WB_i   (prev_killed),
    .had_ex_WB_i        (had_ex),
    .wb_en_i            (wb_en),
    .wb_src_sel_i       (src_sel),
    .inst_wb_i          (inst),
    .alu_out_wb_i       (alu_out),
    .csr_rdata_wb_i     (csr_rdata),
    .dmem_type_wb_i     (dmem_type),
    .dmem_rdata_i       (dmem_rdata),
    .dmem_rvalid_i      (dmem_rvalid),
    .pcpi_rd_wb_i       (pcpi_rd),
    .pcpi_rd2_wb_i      (pcpi_rd2),
    .pcpi_use_rd64_wb_i (pcpi_rd64),
    .stall_WB_o         (stall),
    .rf_we_o            (rf_we),
    .rf_waddr_o         (rf_waddr),
    .rf_wdata_o         (rf_wdata),
    .retire_o           (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d, input logic r);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.ret = r;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    prev_killed = 1'b1;
    had_ex      = 1'b0;
    wb_en       = 1'b0;
    dmem_rvalid = 1'b0;
    pcpi_rd64   = 1'b0;
  endtask

  // One single-cycle op; the selected source carries val, the others ~val.
  task automatic issue(input logic k, input logic e, input logic en, input logic [1:0] s,
                       input logic [4:0] rd, input logic [31:0] val);
    prev_killed = k;
    had_ex      = e;
    wb_en       = en;
    src_sel     = s;
    inst        = {20'h00000, rd, 7'h33};
    alu_out     = ~val;
    csr_rdata   = ~val;
    pcpi_rd     = ~val;
    pcpi_rd64   = 1'b0;
    dmem_rvalid = 1'b0;
    case (s)
      2'd0:    alu_out   = val;
      2'd2:    csr_rdata = val;
      2'd3:    pcpi_rd   = val;
      default: alu_out   = val;
    endcase
    @(negedge clk);
    chk("stall_single", stall, 1'b0);
    next_cycle();
    bubble();
  endtask

  task automatic load_test(input logic [2:0] mt, input logic [1:0] off, input logic [31:0] rdata,
                           input int late, input logic [31:0] expv);
    prev_killed = 1'b0;
    had_ex      = 1'b0;
    wb_en       = 1'b1;
    src_sel     = 2'd1;
    inst        = {20'h00000, 5'd6, 7'h03};
    alu_out     = {30'h00000400, off};
    dmem_type   = mt;
    dmem_rdata  = 32'hDEADBEEF;
    dmem_rvalid = 1'b0;
    for (int i = 0; i < late; i++) begin
      @(negedge clk);
      chk("stall_wait", stall, 1'b1);
      next_cycle();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    push(1'b1, 5'd6, expv, 1'b1);
    @(negedge clk);
    chk("stall_rvalid", stall, 1'b0);
    next_cycle();
    bubble();
  endtask

  task automatic pcpi64(input logic [4:0] rd, input logic [31:0] lo, input logic [31:0] hi,
                        input logic hi_we, input logic [4:0] hi_addr);
    prev_killed = 1'b0;
    had_ex      = 1'b0;
    wb_en       = 1'b1;
    src_sel     = 2'd3;
    inst        = {20'h00000, rd, 7'h33};
    alu_out     = ~lo;
    pcpi_rd     = lo;
    pcpi_rd2    = hi;
    pcpi_rd64   = 1'b1;
    push(1'b1, rd, lo, 1'b0);
    @(negedge clk);
    chk("stall_pcpi_lo", stall, 1'b1);
    next_cycle();
    push(hi_we, hi_addr, hi, 1'b1);
    @(negedge clk);
    chk("stall_pcpi_hi", stall, 1'b0);
    next_cycle();
    bubble();
  endtask

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rf_we || retire) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {rf_we, retire}, 32'h0);
      end else begin
        e = q.pop_front();
        chk("rf_we", rf_we, e.we);
        chk("retire", retire, e.ret);
        if (e.we) begin
          chk("rf_waddr", rf_waddr, e.addr);
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    inst       = 32'h0;
    src_sel    = 2'd0;
    alu_out    = 32'h0;
    csr_rdata  = 32'h0;
    dmem_type  = 3'd2;
    dmem_rdata = 32'h0;
    pcpi_rd    = 32'h0;
    pcpi_rd2   = 32'h0;
    bubble();
    next_cycle();
    next_cycle();
    chk("reset_we", rf_we, 1'b0);
    chk("reset_retire", retire, 1'b0);
    chk("reset_waddr", rf_waddr, 5'd0);
    chk("reset_wdata", rf_wdata, 32'h0);
    chk("reset_stall", stall, 1'b0);
    rst = 1'b0;
    next_cycle();

    // ALU, CSR, single PCPI
    push(1'b1, 5'd5, 32'h12345678, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 2'd0, 5'd5, 32'h12345678);
    push(1'b1, 5'd8, 32'h0C5A0C5A, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 2'd2, 5'd8, 32'h0C5A0C5A);
    push(1'b1, 5'd12, 32'h76543210, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 2'd3, 5'd12, 32'h76543210);

    // Loads
    load_test(3'd0, 2'd3, 32'h80FF0000, 2, 32'hFFFFFF80);
    load_test(3'd4, 2'd3, 32'h80FF0000, 2, 32'h00000080);
    load_test(3'd1, 2'd2, 32'h80FF0000, 1, 32'hFFFF80FF);
    load_test(3'd5, 2'd2, 32'h80FF0000, 0, 32'h000080FF);
    load_test(3'd5, 2'd0, 32'h1234ABCD, 0, 32'h0000ABCD);
    load_test(3'd0, 2'd1, 32'h12345678, 0, 32'h00000056);
    load_test(3'd0, 2'd2, 32'h00A50000, 1, 32'hFFFFFFA5);
    load_test(3'd2, 2'd0, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    load_test(3'd3, 2'd1, 32'h89ABCDEF, 0, 32'h89ABCDEF);

    // 64-bit PCPI, including rd=31 wrapping to x0
    pcpi64(5'd10, 32'hAAAAAAAA, 32'h55555555, 1'b1, 5'd11);
    pcpi64(5'd31, 32'h0BADF00D, 32'h0FEDCBA9, 1'b0, 5'd0);

    // Killed, excepted, x0 and no-writeback ops
    issue(1'b1, 1'b0, 1'b1, 2'd0, 5'd7, 32'h77777777);
    issue(1'b0, 1'b1, 1'b1, 2'd0, 5'd7, 32'h77777777);
    push(1'b0, 5'd0, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 2'd0, 5'd0, 32'h00000BAD);
    push(1'b0, 5'd0, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 1'b0, 2'd0, 5'd9, 32'h99999999);

    // Stray rvalid with no load in WB
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h13579BDF;
    next_cycle();
    bubble();

    // Back-to-back stream
    push(1'b1, 5'd1, 32'h00000001, 1'b1);
    push(1'b1, 5'd2, 32'h00000022, 1'b1);
    push(1'b1, 5'd3, 32'h00000333, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 2'd0, 5'd1, 32'h00000001);
    issue(1'b0, 1'b0, 1'b1, 2'd0, 5'd2, 32'h00000022);
    issue(1'b0, 1'b0, 1'b1, 2'd0, 5'd3, 32'h00000333);

    // Reset while waiting on memory
    push(1'b1, 5'd4, 32'h44440000, 1'b1);
    prev_killed = 1'b0;
    wb_en       = 1'b1;
    src_sel     = 2'd0;
    inst        = {20'h00000, 5'd4, 7'h33};
    alu_out     = 32'h44440000;
    next_cycle();
    src_sel     = 2'd1;
    inst        = {20'h00000, 5'd6, 7'h03};
    dmem_type   = 3'd2;
    dmem_rdata  = 32'hFEEDFACE;
    @(negedge clk);
    chk("stall_load_idle", stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("stall_load_wait", stall, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_stall", stall, 1'b0);
    chk("rst_async_we", rf_we, 1'b0);
    chk("rst_async_retire", retire, 1'b0);
    next_cycle();
    rst = 1'b0;
    bubble();
    dmem_rvalid = 1'b1;
    next_cycle();
    bubble();
    next_cycle();
    push(1'b1, 5'd13, 32'h0000D00D, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 2'd0, 5'd13, 32'h0000D00D);

    repeat (4) next_cycle();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
